// File: rtl/soc_io_page_pkg.sv
// soc_io_page_pkg: shared definitions for the memory-mapped I/O page.
// Holds the register offsets (word offset = mem_addr[5:2]), the
// UART_STATUS bit positions, the TX FSM state encoding and a byte-lane
// merge helper. Firmware headers and the SOC top mirror these values.
package soc_io_page_pkg;

    localparam logic [3:0] OFF_LEDS        = 4'd0;
    localparam logic [3:0] OFF_UART_DATA   = 4'd1;
    localparam logic [3:0] OFF_UART_STATUS = 4'd2;
    localparam logic [3:0] OFF_BAUD_DIV    = 4'd3;

    localparam int ST_BUSY   = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_OVF    = 2;
    localparam int ST_CNT_LO = 4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // Replace the byte lanes of old_v selected by mask with those of new_v.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_v[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/soc_io_page_fifo.sv
// uart_tx_fifo: synchronous byte FIFO feeding the UART transmitter.
// Ports: clk, rst (sync, active-high, flushes), push/din write side,
// pop/dout read side (dout shows the head entry), count/full/empty.
// A push while full is accepted only when a pop happens in the same cycle.
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_pop_s;
    logic          do_push_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= din;
    end

endmodule

// File: rtl/soc_io_page.sv
// soc_io_page: memory-mapped I/O page (LED register + UART 8N1 TX).
// Ports: clk, rst (sync, active-high); processor bus mem_addr, mem_wdata,
// mem_wmask (nonzero = write), mem_rstrb, registered mem_rdata (1-cycle
// latency, holds when not read); outputs led and ftdi_txd (idle high).
// The page is selected by mem_addr[IO_BIT]; unselected accesses are ignored.
module soc_io_page
    import soc_io_page_pkg::*;
#(
    parameter int CLK_HZ     = 25_000_000,
    parameter int BAUD       = 115200,
    parameter int LED_W      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int IO_BIT     = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    input  logic [3:0]       mem_wmask,
    input  logic             mem_rstrb,
    output logic [31:0]      mem_rdata,
    output logic [LED_W-1:0] led,
    output logic             ftdi_txd
);
    localparam logic [15:0] DIV_RESET = 16'(CLK_HZ / BAUD - 1);
    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;

    logic [LED_W-1:0] led_r;
    logic [15:0]      div_r;
    logic             ovf_r;
    logic [31:0]      rdata_r;
    logic             sel_s, wr_s, rd_s, push_s, pop_s;
    logic             ovf_set_s, ovf_clr_s;
    logic [3:0]       off_s;
    logic [31:0]      status_s, rd_val_s, led_merged_s, div_merged_s;
    logic [7:0]       dout_s;
    logic [CW-1:0]    count_s;
    logic             full_s, empty_s;
    logic             unused_bits_s;

    tx_state_t        state_r, state_nxt;
    logic [15:0]      cnt_r, cnt_nxt;
    logic [2:0]       idx_r, idx_nxt;
    logic [7:0]       shift_r, shift_nxt;
    logic             txd_r, txd_nxt;
    logic             bit_end_s;

    assign sel_s     = mem_addr[IO_BIT];
    assign off_s     = mem_addr[5:2];
    assign wr_s      = sel_s & (|mem_wmask);
    assign rd_s      = sel_s & mem_rstrb;
    assign push_s    = wr_s & (off_s == OFF_UART_DATA) & mem_wmask[0];
    assign ovf_set_s = push_s & full_s & ~pop_s;
    assign ovf_clr_s = wr_s & (off_s == OFF_UART_STATUS) & mem_wmask[0] & mem_wdata[ST_OVF];
    assign led_merged_s = merge_bytes(32'(led_r), mem_wdata, mem_wmask);
    assign div_merged_s = merge_bytes({16'd0, div_r}, mem_wdata, mem_wmask);
    assign unused_bits_s = ^{mem_addr, led_merged_s, div_merged_s};

    assign led       = led_r;
    assign ftdi_txd  = txd_r;
    assign mem_rdata = rdata_r;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (mem_wdata[7:0]),
        .dout  (dout_s),
        .count (count_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Status word and read-data selection.
    always_comb begin
        status_s = 32'd0;
        status_s[ST_BUSY] = (state_r != TX_IDLE) | ~empty_s;
        status_s[ST_FULL] = full_s;
        status_s[ST_OVF]  = ovf_r;
        status_s[ST_CNT_LO +: 5] = 5'(count_s);
        case (off_s)
            OFF_LEDS:        rd_val_s = 32'(led_r);
            OFF_UART_STATUS: rd_val_s = status_s;
            OFF_BAUD_DIV:    rd_val_s = {16'd0, div_r};
            default:         rd_val_s = 32'd0;
        endcase
    end

    // Bus-visible registers: LEDs, divisor, sticky overflow, read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_r   <= {LED_W{1'b0}};
            div_r   <= DIV_RESET;
            ovf_r   <= 1'b0;
            rdata_r <= 32'd0;
        end else begin
            if (wr_s && off_s == OFF_LEDS)     led_r <= led_merged_s[LED_W-1:0];
            if (wr_s && off_s == OFF_BAUD_DIV) div_r <= div_merged_s[15:0];
            // A same-cycle overflow beats a software clear.
            if (ovf_set_s)      ovf_r <= 1'b1;
            else if (ovf_clr_s) ovf_r <= 1'b0;
            if (rd_s) rdata_r <= rd_val_s;
        end
    end

    assign bit_end_s = (cnt_r == 16'd0);

    // TX FSM next state; the divisor is sampled only at bit-counter reloads.
    always_comb begin
        state_nxt = state_r;
        cnt_nxt   = cnt_r;
        idx_nxt   = idx_r;
        shift_nxt = shift_r;
        txd_nxt   = txd_r;
        pop_s     = 1'b0;
        if (state_r != TX_IDLE) begin
            cnt_nxt = bit_end_s ? div_r : (cnt_r - 16'd1);
        end else begin
            cnt_nxt = cnt_r;
        end
        case (state_r)
            TX_IDLE: begin
                txd_nxt = 1'b1;
                if (!empty_s) begin
                    pop_s     = 1'b1;
                    shift_nxt = dout_s;
                    txd_nxt   = 1'b0;
                    cnt_nxt   = div_r;
                    state_nxt = TX_START;
                end else begin
                    state_nxt = TX_IDLE;
                end
            end
            TX_START: begin
                if (bit_end_s) begin
                    state_nxt = TX_DATA;
                    txd_nxt   = shift_r[0];
                    shift_nxt = {1'b0, shift_r[7:1]};
                    idx_nxt   = 3'd0;
                end else begin
                    state_nxt = TX_START;
                end
            end
            TX_DATA: begin
                if (bit_end_s && idx_r == 3'd7) begin
                    state_nxt = TX_STOP;
                    txd_nxt   = 1'b1;
                end else if (bit_end_s) begin
                    txd_nxt   = shift_r[0];
                    shift_nxt = {1'b0, shift_r[7:1]};
                    idx_nxt   = idx_r + 3'd1;
                end else begin
                    state_nxt = TX_DATA;
                end
            end
            TX_STOP: begin
                if (bit_end_s) begin
                    state_nxt = TX_IDLE;
                end else begin
                    state_nxt = TX_STOP;
                end
                txd_nxt = 1'b1;
            end
            default: begin
                state_nxt = TX_IDLE;
                txd_nxt   = 1'b1;
            end
        endcase
    end

    // TX FSM registers; reset aborts any frame and drives the line high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= TX_IDLE;
            cnt_r   <= 16'd0;
            idx_r   <= 3'd0;
            shift_r <= 8'd0;
            txd_r   <= 1'b1;
        end else begin
            state_r <= state_nxt;
            cnt_r   <= cnt_nxt;
            idx_r   <= idx_nxt;
            shift_r <= shift_nxt;
            txd_r   <= txd_nxt;
        end
    end

endmodule

// File: tb/tb_soc_io_page.sv
// tb_soc_io_page: directed stimulus for soc_io_page with a frame-level
// reference model (time-based UART frames, queue-based FIFO) compared
// against led, ftdi_txd and mem_rdata on every falling edge, plus literal
// expectations at key points.
module tb_soc_io_page;
    localparam int          LED_W   = 8;
    localparam int          DEPTH   = 4;
    localparam logic [15:0] DIV_DEF = 16'd216;
    localparam logic [31:0] IO      = 32'h0040_0000;
    localparam logic [3:0]  O_LED = 4'd0, O_DAT = 4'd1, O_STA = 4'd2, O_DIV = 4'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;
    logic [LED_W-1:0] led;
    logic        ftdi_txd;

    int n_cmp = 0;
    int n_bad = 0;

    soc_io_page #(.LED_W(LED_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata),
        .led(led), .ftdi_txd(ftdi_txd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          k = 0;          // index of the last rising edge
    bit          m_live = 1'b0;
    logic [7:0]  q[$];
    logic        m_ovf;
    logic [31:0] m_led, m_rdata;
    logic [15:0] m_div;
    int          fc = 0, fd = 0, fend = 0;   // frame start edge, divisor, end edge
    logic [7:0]  fb;

    function automatic logic m_txd();
        int j;
        if (k < fend) begin
            j = (k - fc) / (fd + 1);
            if (j == 0) return 1'b0;
            else if (j <= 8) return fb[j-1];
            else return 1'b1;
        end else begin
            return 1'b1;
        end
    endfunction

    always @(posedge clk) begin
        logic        sel, wr, rd, ovf_set, busy, full;
        logic [3:0]  off;
        logic [31:0] st, tmp;
        k = k + 1;
        if (rst) begin
            m_live = 1'b1;
            q.delete();
            m_ovf = 1'b0; m_led = 32'd0; m_rdata = 32'd0; m_div = DIV_DEF;
            fend = k;
        end else if (m_live) begin
            sel = mem_addr[22];
            off = mem_addr[5:2];
            wr  = sel && (mem_wmask != 4'd0);
            rd  = sel && mem_rstrb;
            busy = (k - 1 < fend) || (q.size() > 0);
            full = (q.size() == DEPTH);
            st = {23'd0, 5'(q.size()), 1'b0, m_ovf, full, busy};
            if (rd) begin
                if (off == O_LED)      m_rdata = m_led;
                else if (off == O_STA) m_rdata = st;
                else if (off == O_DIV) m_rdata = {16'd0, m_div};
                else                   m_rdata = 32'd0;
            end
            if (k > fend && q.size() > 0) begin
                fb = q.pop_front(); fc = k; fd = int'(m_div); fend = k + 10 * (fd + 1);
            end
            ovf_set = 1'b0;
            if (wr && off == O_DAT && mem_wmask[0]) begin
                if (q.size() < DEPTH) q.push_back(mem_wdata[7:0]);
                else ovf_set = 1'b1;
            end
            if (ovf_set) m_ovf = 1'b1;
            else if (wr && off == O_STA && mem_wmask[0] && mem_wdata[2]) m_ovf = 1'b0;
            if (wr && (off == O_LED || off == O_DIV)) begin
                tmp = (off == O_LED) ? m_led : {16'd0, m_div};
                for (int i = 0; i < 4; i++)
                    if (mem_wmask[i]) tmp[8*i +: 8] = mem_wdata[8*i +: 8];
                if (off == O_LED) m_led = tmp & 32'((64'd1 << LED_W) - 64'd1);
                else m_div = tmp[15:0];
            end
        end
    end

    // Compare process: every falling edge once the model has seen reset.
    always @(negedge clk) begin
        if (m_live) begin
            check("txd",   {31'd0, ftdi_txd}, {31'd0, m_txd()});
            check("led",   32'(led), m_led);
            check("rdata", mem_rdata, m_rdata);
        end
    end

    // ---------------- bus tasks ----------------
    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, input logic r);
        @(negedge clk);
        mem_addr = a; mem_wdata = d; mem_wmask = m; mem_rstrb = r;
    endtask
    task automatic nop();
        drive(32'd0, 32'd0, 4'd0, 1'b0);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) nop();
    endtask
    task automatic wr(input logic [3:0] off, input logic [31:0] d, input logic [3:0] m);
        drive(IO | {26'd0, off, 2'd0}, d, m, 1'b0);
    endtask
    task automatic rd(input logic [3:0] off, input logic [31:0] exp, input string name);
        drive(IO | {26'd0, off, 2'd0}, 32'd0, 4'd0, 1'b1);
        nop();
        check(name, mem_rdata, exp);
    endtask

    logic [9:0] pat_55;

    initial begin
        rst = 1'b1; mem_addr = 32'd0; mem_wdata = 32'd0; mem_wmask = 4'd0; mem_rstrb = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(20);
        check("rst_txd", {31'd0, ftdi_txd}, 32'd1);
        check("rst_led", 32'(led), 32'd0);
        rd(O_STA, 32'd0, "rst_status");
        rd(O_DIV, 32'd216, "rst_div");

        // LED byte masking
        wr(O_LED, 32'h0000_00A5, 4'b0001);
        wr(O_LED, 32'hFFFF_FF3C, 4'b0010);
        nop();
        check("led_a5", 32'(led), 32'h0000_00A5);
        rd(O_LED, 32'h0000_00A5, "led_read");

        // Single frame 0x55 at 4 cycles per bit
        wr(O_DIV, 32'd3, 4'b0011);
        wr(O_DAT, 32'h55, 4'b0001);
        nop();
        pat_55 = 10'b10_1010_1010;   // bit i = level of frame bit i
        repeat (2) @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("frame55_bit%0d", i), {31'd0, ftdi_txd}, {31'd0, pat_55[i]});
            repeat (4) @(posedge clk);
        end
        rd(O_STA, 32'd0, "status_after_55");

        // Overflow: six back-to-back pushes into a 4-deep FIFO
        wr(O_DAT, 32'h11, 4'b0001);
        wr(O_DAT, 32'h22, 4'b0001);
        wr(O_DAT, 32'h33, 4'b0001);
        wr(O_DAT, 32'h44, 4'b0001);
        wr(O_DAT, 32'h55, 4'b0001);
        wr(O_DAT, 32'h66, 4'b0001);
        rd(O_STA, 32'h0000_0047, "status_ovf_full");
        wr(O_STA, 32'h4, 4'b0001);
        rd(O_STA, 32'h0000_0043, "status_ovf_clr");
        idle(230);
        rd(O_STA, 32'd0, "status_drained");

        // Unselected accesses are ignored; rdata holds
        rd(O_LED, 32'h0000_00A5, "led_read2");
        drive({26'd0, O_DAT, 2'd0}, 32'h00, 4'b0001, 1'b0);
        drive({26'd0, O_LED, 2'd0}, 32'hFF, 4'b1111, 1'b0);
        drive({26'd0, O_DIV, 2'd0}, 32'h0, 4'b0000, 1'b1);
        nop();
        check("unsel_rdata_hold", mem_rdata, 32'h0000_00A5);
        idle(30);
        check("unsel_led", 32'(led), 32'h0000_00A5);
        rd(O_STA, 32'd0, "unsel_status");

        // Reset in the middle of data bit 3
        wr(O_DIV, 32'd3, 4'b0011);
        wr(O_DAT, 32'hA3, 4'b0001);
        wr(O_DAT, 32'hC4, 4'b0001);
        nop();
        repeat (17) @(negedge clk);
        check("pre_reset_bit3", {31'd0, ftdi_txd}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("reset_txd", {31'd0, ftdi_txd}, 32'd1);
        rd(O_STA, 32'd0, "reset_status");
        rd(O_DIV, 32'd216, "reset_div");
        idle(300);
        check("reset_no_frames", {31'd0, ftdi_txd}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
